// File: rtl/lbp_image_host.sv
// Memory-side responder for the LBP engine: image RAM, result RAM, write count and checksum.
// Define LBP_IMAGE_HOST_CHECK_EN to add duplicate-write and incomplete-frame checking.
module lbp_image_host #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 8,
  parameter int NUM_PIX = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [DATA_W-1:0] gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   wr_count,
  output logic [15:0]       checksum,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {LOAD, ARM, RUN, DONE} state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(NUM_PIX);

  state_t state, state_next;

  logic [DATA_W-1:0] img [NUM_PIX];
  logic [DATA_W-1:0] res [NUM_PIX];

  logic            img_write;
  logic            run_write;
  logic [ADDR_W:0] count_next;
  logic            err_set;

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (load_done) state_next = ARM;
      ARM:     state_next = RUN;
      RUN:     if (finish) state_next = DONE;
      default: state_next = DONE;
    endcase
  end

  always_comb begin
    gray_ready = (state == RUN);
    done       = (state == DONE);
    img_write  = (state == LOAD) && load_valid;
    run_write  = (state == RUN) && lbp_valid;
    gray_data  = ((state == RUN) && gray_req) ? img[gray_addr] : '0;
  end

  // Memories are never reset; the image persists across frames until reloaded.
  always_ff @(posedge clk) begin
    if (img_write) img[load_addr] <= load_data;
    if (run_write) res[lbp_addr] <= lbp_data;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= res[rd_addr];
  end

  always_comb begin
    count_next = wr_count;
    if (run_write && (wr_count != FULL)) count_next = wr_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || (state == ARM)) begin
      wr_count <= '0;
      checksum <= '0;
    end else if (run_write) begin
      wr_count <= count_next;
      checksum <= checksum + 16'(lbp_data);
    end
  end

`ifdef LBP_IMAGE_HOST_CHECK_EN
  logic [NUM_PIX-1:0] written;

  always_ff @(posedge clk) begin
    if (state == ARM)   written <= '0;
    else if (run_write) written[lbp_addr] <= 1'b1;
  end

  always_comb begin
    err_set = (gray_req && (state != RUN)) ||
              (finish && (state != RUN)) ||
              (lbp_valid && (state == DONE)) ||
              (run_write && written[lbp_addr]) ||
              ((state == RUN) && finish && (count_next != FULL));
  end
`else
  always_comb begin
    err_set = (gray_req && (state != RUN)) ||
              (finish && (state != RUN)) ||
              (lbp_valid && (state == DONE));
  end
`endif

  always_ff @(posedge clk) begin
    if (reset)        err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

endmodule

// File: tb/tb_lbp_image_host.sv
// Self-checking bench for lbp_image_host; readback data is checked through an expected-value queue.
module tb_lbp_image_host;

`ifdef LBP_IMAGE_HOST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0;
  logic [13:0] load_addr = '0;
  logic [7:0]  load_data = '0;
  logic        load_done = 1'b0;
  logic        gray_ready;
  logic        gray_req = 1'b0;
  logic [13:0] gray_addr = '0;
  logic [7:0]  gray_data;
  logic        lbp_valid = 1'b0;
  logic [13:0] lbp_addr = '0;
  logic [7:0]  lbp_data = '0;
  logic        finish = 1'b0;
  logic [13:0] rd_addr = '0;
  logic [7:0]  rd_data;
  logic [14:0] wr_count;
  logic [15:0] checksum;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  res_model [16384];
  logic [7:0]  exp_q [$];
  int          cnt_model = 0;
  logic [15:0] chk_model = '0;

  lbp_image_host dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
    .gray_ready(gray_ready), .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_count(wr_count), .checksum(checksum), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cnt_model = 0;
    chk_model = '0;
    exp_q.delete();
  endtask

  task automatic load_pixel(input int a, input logic [7:0] d, input bit last);
    load_valid = 1'b1;
    load_addr  = 14'(a);
    load_data  = d;
    load_done  = last;
    tick();
    load_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  task automatic lbp_write(input int a, input logic [7:0] d, input bit fin);
    lbp_valid = 1'b1;
    lbp_addr  = 14'(a);
    lbp_data  = d;
    finish    = fin;
    res_model[a] = d;
    if (cnt_model < 16384) cnt_model++;
    chk_model = chk_model + 16'(d);
    tick();
    lbp_valid = 1'b0;
    finish    = 1'b0;
  endtask

  task automatic gray_probe(input string tag, input logic [13:0] a, input logic [7:0] expected);
    gray_req  = 1'b1;
    gray_addr = a;
    #1;
    check_output(tag, 32'(gray_data), 32'(expected));
    gray_req = 1'b0;
    #1;
    check_output({tag, "_idle"}, 32'(gray_data), 32'h0);
  endtask

  task automatic request_read(input int a);
    rd_addr = 14'(a);
    exp_q.push_back(res_model[a]);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check_output({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_output(tag, 32'(rd_data), 32'(e));
    end
  endtask

  task automatic check_counters(input string tag);
    check_output({tag, "_wr_count"}, 32'(wr_count), 32'(cnt_model));
    check_output({tag, "_checksum"}, 32'(checksum), 32'(chk_model));
  endtask

  initial begin
    do_reset();
    check_output("rst_gray_ready", 32'(gray_ready), 32'h0);
    check_output("rst_gray_data", 32'(gray_data), 32'h0);
    check_output("rst_rd_data", 32'(rd_data), 32'h0);
    check_output("rst_done", 32'(done), 32'h0);
    check_output("rst_err", 32'(err), 32'h0);
    check_counters("rst");

    for (int a = 0; a < 16384; a++) load_pixel(a, 8'(a), a == 16383);
    check_output("arm_gray_ready", 32'(gray_ready), 32'h0);
    tick();
    check_output("run_gray_ready", 32'(gray_ready), 32'h1);
    gray_probe("gray_0081", 14'h0081, 8'h81);
    gray_probe("gray_3fff", 14'h3FFF, 8'hFF);
    gray_probe("gray_last_load", 14'h3FFF, 8'hFF);

    lbp_write(5, 8'hA5, 1'b0);
    lbp_write(6, 8'h5A, 1'b0);
    request_read(5);
    check_output("two_wr_count", 32'(wr_count), 32'd2);
    check_output("two_checksum", 32'(checksum), 32'h00FF);
    tick();
    pop_check("rd_5");

    request_read(5);
    lbp_write(5, 8'h33, 1'b0);
    pop_check("rd_old_on_collision");
    request_read(5);
    tick();
    pop_check("rd_new_after_write");
    check_counters("three");

    finish = 1'b1;
    tick();
    finish = 1'b0;
    check_output("a_done", 32'(done), 32'h1);
    check_output("a_gray_ready", 32'(gray_ready), 32'h0);
    check_output("a_err_incomplete", 32'(err), 32'(CHK));
    lbp_valid = 1'b1;
    lbp_addr  = 14'd9;
    lbp_data  = 8'h77;
    tick();
    lbp_valid = 1'b0;
    check_output("done_lbp_err", 32'(err), 32'h1);
    check_counters("done_ignored");

    do_reset();
    check_output("rst2_err", 32'(err), 32'h0);
    check_output("rst2_done", 32'(done), 32'h0);
    check_output("rst2_gray_ready", 32'(gray_ready), 32'h0);
    check_counters("rst2");

    gray_req  = 1'b1;
    gray_addr = 14'h0081;
    #1;
    check_output("load_gray_data", 32'(gray_data), 32'h0);
    tick();
    gray_req = 1'b0;
    check_output("load_gray_err", 32'(err), 32'h1);
    do_reset();
    check_output("rst3_err", 32'(err), 32'h0);
    check_output("rst3_gray_ready", 32'(gray_ready), 32'h0);

    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    tick();
    check_output("b_gray_ready", 32'(gray_ready), 32'h1);
    load_pixel(16'h0082, 8'hEE, 1'b0);
    gray_probe("run_load_ignored", 14'h0082, 8'h82);
    for (int a = 0; a < 16384; a++) lbp_write(a, 8'hFF, a == 16383);
    check_output("full_done", 32'(done), 32'h1);
    check_output("full_wr_count", 32'(wr_count), 32'd16384);
    check_output("full_checksum", 32'(checksum), 32'hC000);
    check_output("full_err", 32'(err), 32'h0);
    check_counters("full_model");
    request_read(5);
    tick();
    pop_check("full_rd_5");
    request_read(16383);
    tick();
    pop_check("full_rd_3fff");

    do_reset();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    tick();
    lbp_write(7, 8'h11, 1'b0);
    lbp_write(7, 8'h22, 1'b0);
    check_output("dup_err", 32'(err), 32'(CHK));
    request_read(7);
    tick();
    pop_check("dup_rd_7");
    for (int i = 0; i < 98; i++) lbp_write(100 + i, 8'(i), 1'b0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    check_output("c_done", 32'(done), 32'h1);
    check_output("c_err", 32'(err), 32'(CHK));
    check_counters("c_hundred");

    do_reset();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    tick();
    for (int i = 0; i < 50; i++) lbp_write(i, 8'h01, 1'b0);
    check_output("d_wr_count_50", 32'(wr_count), 32'd50);
    do_reset();
    check_output("d_rst_wr_count", 32'(wr_count), 32'd0);
    check_output("d_rst_gray_ready", 32'(gray_ready), 32'h0);
    load_pixel(16'h0081, 8'h3C, 1'b1);
    check_output("d_arm_gray_ready", 32'(gray_ready), 32'h0);
    tick();
    check_output("d_run_gray_ready", 32'(gray_ready), 32'h1);
    gray_probe("d_reloaded_pixel", 14'h0081, 8'h3C);
    check_output("d_err", 32'(err), 32'h0);
    check_counters("d_rearm");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
